// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM write arbiter.
// Holds data/address width defaults, target encoding and window-state encoding.
package vram_pkg;

    localparam int DATA_W_DEF = 39;
    localparam int ADDR_W_DEF = 16;

    localparam logic TGT_BG  = 1'b0;
    localparam logic TGT_OAM = 1'b1;

    typedef enum logic {
        WIN_CLOSED = 1'b0,
        WIN_OPEN   = 1'b1
    } win_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with per-requester eligibility mask.
// ptr names the requester that wins a tie; output grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] elig,
    input  logic       ptr,
    output logic [1:0] gnt
);

    logic [1:0] r;

    always_comb begin
        r   = req & elig;
        gnt = 2'b00;
        if (r == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = r;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates two requesters onto the bg_ram / oam write ports.
// VRAM_ARB_WINDOW_EN enables the frame-tick write window; otherwise writes are always allowed.
module vram_write_arbiter
    import vram_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int WINDOW_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_tick,
    input  logic [1:0]        req,
    input  logic [1:0]        tgt,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic [1:0]        ack,
    output logic [ADDR_W-1:0] bg_addr,
    output logic [DATA_W-1:0] bg_din,
    output logic              bg_wea,
    output logic [2:0]        oam_addr,
    output logic [31:0]       oam_din,
    output logic              oam_wea,
    output logic              win_open
);

    logic grant_en;

`ifdef VRAM_ARB_WINDOW_EN
    localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);

    win_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= WIN_CLOSED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WIN_CLOSED: begin
                if (f_tick) begin
                    state_d = WIN_OPEN;
                    cnt_d   = CNT_W'(WINDOW_CYCLES - 1);
                end
            end
            WIN_OPEN: begin
                if (f_tick) begin
                    cnt_d = CNT_W'(WINDOW_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = WIN_CLOSED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = WIN_CLOSED;
        endcase
    end

    // The last open cycle grants nothing, so no write lands after close.
    always_comb begin
        win_open = (state_q == WIN_OPEN);
        grant_en = win_open && (f_tick || (cnt_q != '0));
    end
`else
    logic win_open_q;
    logic unused_f_tick;

    assign unused_f_tick = f_tick;

    always_ff @(posedge clk) begin
        if (clr) begin
            win_open_q <= 1'b0;
        end else begin
            win_open_q <= 1'b1;
        end
    end

    assign win_open = win_open_q;
    assign grant_en = 1'b1;
`endif

    logic [1:0]        gnt, issue;
    logic [1:0]        inelig_q, inelig_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        ack_q, ack_d;
    logic              bg_wea_q, bg_wea_d;
    logic              oam_wea_q, oam_wea_d;
    logic [ADDR_W-1:0] bg_addr_q, bg_addr_d;
    logic [DATA_W-1:0] bg_din_q, bg_din_d;
    logic [2:0]        oam_addr_q, oam_addr_d;
    logic [31:0]       oam_din_q, oam_din_d;
    logic              tgt_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] din_s;

    rr_arb2 u_arb (
        .req  (req),
        .elig (~inelig_q),
        .ptr  (ptr_q),
        .gnt  (gnt)
    );

    always_comb begin
        issue  = grant_en ? gnt : 2'b00;
        tgt_s  = issue[1] ? tgt[1] : tgt[0];
        addr_s = issue[1] ? addr1 : addr0;
        din_s  = issue[1] ? din1 : din0;

        ack_d     = issue;
        inelig_d  = issue;
        ptr_d     = ptr_q;
        if (issue[0]) ptr_d = 1'b1;
        if (issue[1]) ptr_d = 1'b0;

        bg_wea_d   = (|issue) && (tgt_s == TGT_BG);
        oam_wea_d  = (|issue) && (tgt_s == TGT_OAM);
        bg_addr_d  = bg_wea_d ? addr_s : bg_addr_q;
        bg_din_d   = bg_wea_d ? din_s : bg_din_q;
        oam_addr_d = oam_wea_d ? addr_s[2:0] : oam_addr_q;
        oam_din_d  = oam_wea_d ? din_s[31:0] : oam_din_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            inelig_q   <= 2'b00;
            ptr_q      <= 1'b0;
            ack_q      <= 2'b00;
            bg_wea_q   <= 1'b0;
            oam_wea_q  <= 1'b0;
            bg_addr_q  <= '0;
            bg_din_q   <= '0;
            oam_addr_q <= '0;
            oam_din_q  <= '0;
        end else begin
            inelig_q   <= inelig_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            bg_wea_q   <= bg_wea_d;
            oam_wea_q  <= oam_wea_d;
            bg_addr_q  <= bg_addr_d;
            bg_din_q   <= bg_din_d;
            oam_addr_q <= oam_addr_d;
            oam_din_q  <= oam_din_d;
        end
    end

    assign ack      = ack_q;
    assign bg_wea   = bg_wea_q;
    assign oam_wea  = oam_wea_q;
    assign bg_addr  = bg_addr_q;
    assign bg_din   = bg_din_q;
    assign oam_addr = oam_addr_q;
    assign oam_din  = oam_din_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter (window and always-open builds).
// Selects its vectors by VRAM_ARB_WINDOW_EN.
module tb_vram_write_arbiter;

    localparam int DW = 39;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          f_tick = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [1:0]    tgt = 2'b00;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] din0 = '0;
    logic [DW-1:0] din1 = '0;
    logic [1:0]    ack;
    logic [AW-1:0] bg_addr;
    logic [DW-1:0] bg_din;
    logic          bg_wea;
    logic [2:0]    oam_addr;
    logic [31:0]   oam_din;
    logic          oam_wea;
    logic          win_open;

    int n_chk = 0;
    int n_err = 0;
    int n0;
    int n1;

    vram_write_arbiter #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .WINDOW_CYCLES (4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .f_tick   (f_tick),
        .req      (req),
        .tgt      (tgt),
        .addr0    (addr0),
        .addr1    (addr1),
        .din0     (din0),
        .din1     (din1),
        .ack      (ack),
        .bg_addr  (bg_addr),
        .bg_din   (bg_din),
        .bg_wea   (bg_wea),
        .oam_addr (oam_addr),
        .oam_din  (oam_din),
        .oam_wea  (oam_wea),
        .win_open (win_open)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Both requesters held for six grant cycles; acks must alternate.
    task automatic contention();
        logic [1:0] exp_ack;
        n0 = 0;
        n1 = 0;
        req   = 2'b11;
        tgt   = 2'b10;
        addr0 = 16'h0100;
        addr1 = 16'h0006;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_ack%0d", i), 64'(ack), 64'(exp_ack));
            if (ack == 2'b01) n0++;
            if (ack == 2'b10) n1++;
        end
        req = 2'b00;
        check("rr_cnt0", 64'(n0), 64'd3);
        check("rr_cnt1", 64'(n1), 64'd3);
    endtask

    initial begin
        tick();
        tick();
        check("rst_win", 64'(win_open), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_bgw", 64'(bg_wea), 64'd0);
        check("rst_bga", 64'(bg_addr), 64'd0);
        check("rst_oaa", 64'(oam_addr), 64'd0);
        clr = 1'b0;

`ifdef VRAM_ARB_WINDOW_EN
        // Closed window: no write until a frame tick.
        req[1] = 1'b1;
        tgt[1] = 1'b1;
        addr1  = 16'd5;
        din1   = 39'h00CAFE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cls_oamw", 64'(oam_wea), 64'd0);
        end
        f_tick = 1'b1;
        tick();
        f_tick = 1'b0;
        check("opn_win", 64'(win_open), 64'd1);
        check("opn_oamw", 64'(oam_wea), 64'd0);
        tick();
        check("oam_w", 64'(oam_wea), 64'd1);
        check("oam_a", 64'(oam_addr), 64'd5);
        check("oam_d", 64'(oam_din), 64'h00CAFE);
        check("oam_ack", 64'(ack), 64'b10);
        req[1] = 1'b0;
        tick();
        check("oam_w0", 64'(oam_wea), 64'd0);
        check("oam_hold", 64'(oam_addr), 64'd5);
        tick();
        tick();
        tick();
        check("cls_win", 64'(win_open), 64'd0);

        // Single request one cycle after f_tick.
        f_tick = 1'b1;
        tick();
        f_tick = 1'b0;
        req[0] = 1'b1;
        tgt[0] = 1'b0;
        addr0  = 16'h0010;
        din0   = 39'h12345;
        tick();
        check("s_bgw", 64'(bg_wea), 64'd1);
        check("s_bga", 64'(bg_addr), 64'h0010);
        check("s_bgd", 64'(bg_din), 64'h12345);
        check("s_ack", 64'(ack), 64'b01);
        check("s_oamw", 64'(oam_wea), 64'd0);
        tick();
        check("s_dup_ack", 64'(ack), 64'd0);
        check("s_dup_w", 64'(bg_wea), 64'd0);
        req[0] = 1'b0;
        tick();

        // Request arriving at counter 0 waits for the next window.
        req[0] = 1'b1;
        addr0  = 16'h0022;
        tick();
        check("e_bgw", 64'(bg_wea), 64'd0);
        check("e_win", 64'(win_open), 64'd0);
        tick();
        check("e_bgw2", 64'(bg_wea), 64'd0);
        f_tick = 1'b1;
        tick();
        f_tick = 1'b0;
        check("e_bgw3", 64'(bg_wea), 64'd0);
        tick();
        check("e_srv_w", 64'(bg_wea), 64'd1);
        check("e_srv_a", 64'(bg_addr), 64'h0022);
        check("e_srv_k", 64'(ack), 64'b01);
        req[0] = 1'b0;

        // f_tick on the last open cycle extends the window.
        tick();
        tick();
        f_tick = 1'b1;
        req[1] = 1'b1;
        tgt[1] = 1'b0;
        addr1  = 16'h0033;
        tick();
        f_tick = 1'b0;
        req[1] = 1'b0;
        check("x_win", 64'(win_open), 64'd1);
        check("x_bgw", 64'(bg_wea), 64'd1);
        check("x_bga", 64'(bg_addr), 64'h0033);
        check("x_ack", 64'(ack), 64'b10);

        // Keep the window alive with frame ticks during contention.
        f_tick = 1'b1;
        contention();
        f_tick = 1'b0;

        // Reset mid-window aborts it; held request waits for f_tick.
        req[0] = 1'b1;
        tgt[0] = 1'b0;
        addr0  = 16'h0044;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        check("r_win", 64'(win_open), 64'd0);
        check("r_ack", 64'(ack), 64'd0);
        check("r_bgw", 64'(bg_wea), 64'd0);
        check("r_bga", 64'(bg_addr), 64'd0);
        check("r_oaa", 64'(oam_addr), 64'd0);
        tick();
        tick();
        check("r_wait", 64'(bg_wea), 64'd0);
        f_tick = 1'b1;
        tick();
        f_tick = 1'b0;
        tick();
        check("r_srv_w", 64'(bg_wea), 64'd1);
        check("r_srv_a", 64'(bg_addr), 64'h0044);
        req[0] = 1'b0;
`else
        tick();
        check("open_win", 64'(win_open), 64'd1);

        // Single request, no frame tick needed.
        req[0] = 1'b1;
        tgt[0] = 1'b0;
        addr0  = 16'h0010;
        din0   = 39'h12345;
        tick();
        check("s_bgw", 64'(bg_wea), 64'd1);
        check("s_bga", 64'(bg_addr), 64'h0010);
        check("s_bgd", 64'(bg_din), 64'h12345);
        check("s_ack", 64'(ack), 64'b01);
        tick();
        check("s_dup_ack", 64'(ack), 64'd0);
        check("s_dup_w", 64'(bg_wea), 64'd0);
        req[0] = 1'b0;
        tick();
        check("s_hold", 64'(bg_addr), 64'h0010);

        // OAM write uses the low address and data bits.
        req[1] = 1'b1;
        tgt[1] = 1'b1;
        addr1  = 16'h00FD;
        din1   = 39'hABCDEF012;
        tick();
        check("oam_w", 64'(oam_wea), 64'd1);
        check("oam_a", 64'(oam_addr), 64'd5);
        check("oam_d", 64'(oam_din), 64'hBCDEF012);
        check("oam_bgw", 64'(bg_wea), 64'd0);
        req[1] = 1'b0;

        contention();

        // Reset then immediate service of the held request.
        req[0] = 1'b1;
        tgt[0] = 1'b0;
        addr0  = 16'h0044;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        check("r_win", 64'(win_open), 64'd0);
        check("r_ack", 64'(ack), 64'd0);
        check("r_bga", 64'(bg_addr), 64'd0);
        tick();
        check("r_srv_w", 64'(bg_wea), 64'd1);
        check("r_srv_a", 64'(bg_addr), 64'h0044);
        req[0] = 1'b0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 39, write-data width of each requester.
REQ-002 SHALL have parameter ADDR_W, default 16, write-address width of each requester.
REQ-003 SHALL have parameter WINDOW_CYCLES, default 1000, length of the write window in clk cycles after each frame tick.
REQ-004 clk  input  1  system clock; one clock; all logic on its rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 f_tick  input  1  one-cycle frame-start pulse from vga_sync.
REQ-007 req[1:0]  input  2  per-requester write request; requester 0 is the game engine, requester 1 is the HUD/score updater.
REQ-008 tgt[1:0]  input  2  per-requester target: 0 = bg_ram, 1 = oam.
REQ-009 addr0, addr1  input  ADDR_W each  requester write addresses.
REQ-010 din0, din1  input  DATA_W each  requester write data.
REQ-011 ack[1:0]  output  2  one-cycle acknowledge: the write has been issued.
REQ-012 bg_addr, bg_din, bg_wea  output  ADDR_W, DATA_W, 1  bg_ram port-A write bus.
REQ-013 oam_addr, oam_din, oam_wea  output  3, 32, 1  oam port-A write bus; driven from addr[2:0] and din[31:0].
REQ-014 win_open  output  1  high while writes are permitted.

Function
REQ-015 Window FSM SHALL have states CLOSED and OPEN: CLOSED->OPEN on f_tick with the down-counter loaded to WINDOW_CYCLES-1; OPEN->CLOSED in the cycle after the counter reaches 0; f_tick while OPEN reloads the counter and stays OPEN.
REQ-016 win_open SHALL be registered and equal (state==OPEN).
REQ-017 Grants SHALL be decided only in cycles where win_open is 1; no write is issued while CLOSED.
REQ-018 At most one write per cycle SHALL be issued, to exactly one of bg_ram or oam, selected by the granted requester's tgt bit.
REQ-019 Arbitration SHALL be round-robin: on a tie, the requester not granted most recently wins; the pointer advances only on a grant.
REQ-020 A requester granted in cycle N SHALL be ineligible in cycle N+1, so a held req never produces a duplicate write.
REQ-021 Latency: req sampled high at edge N with the window open SHALL give registered ack, wea, addr and data at edge N+1, all in the same cycle.
REQ-022 Requesters SHALL hold req, tgt, addr and din stable until ack. The arbiter SHALL NOT drop a pending request, and a request pending at window close SHALL be served in the next window.
REQ-023 wea and ack SHALL be single-cycle pulses. Address and data outputs SHALL hold their last value when wea is 0.
REQ-024 If f_tick and the last window cycle coincide, the window SHALL remain OPEN with the counter reloaded.

Reset
REQ-025 On clr SHALL force state CLOSED, counter 0, round-robin pointer to requester 0, ineligibility cleared, and all outputs 0.
REQ-026 clr asserted mid-window SHALL abort the window. Requests still held after clr SHALL wait for the next f_tick.

Configuration
REQ-027 Macro VRAM_ARB_WINDOW_EN defined: window gating per REQ-015..REQ-017 and REQ-024.
REQ-028 VRAM_ARB_WINDOW_EN undefined: the window FSM and counter SHALL be omitted, win_open tied to 1 after reset, and grants allowed every cycle, with f_tick ignored.

Structure
REQ-029 Shared package vram_pkg SHALL hold DATA_W/ADDR_W defaults, the target encoding constants TGT_BG=0 and TGT_OAM=1, and the window-state encoding.
REQ-030 The round-robin grant logic SHALL be one sub-module, rr_arb2, with inputs req, eligibility and pointer, and output a one-hot grant.

Verification
REQ-031 Single request: req0=1, tgt0=0, addr0=0x0010, din0=0x12345 one cycle after f_tick -> next cycle bg_wea=1, bg_addr=0x0010, ack=2'b01, for exactly one cycle.
REQ-032 Contention: both req held for 6 window cycles -> acks alternate 01,10,01,... giving 3 writes each, with no duplicates.
REQ-033 Closed window: req1=1, tgt1=1, addr1=5 with no f_tick -> no oam_wea. After f_tick -> oam_wea=1, oam_addr=3'd5 one cycle later.
REQ-034 Window edge: WINDOW_CYCLES=4 with a request arriving at counter 0 -> not served; served on the next f_tick. Also f_tick on the last cycle extends the window.
REQ-035 Reset mid-window: clr pulsed while OPEN with req0 held -> all outputs 0 and win_open 0 next cycle, then served after the following f_tick. Rerun with VRAM_ARB_WINDOW_EN undefined -> served without f_tick.
